// File: rtl/booth_mul_pkg.sv
// Package for the iterative radix-4 Booth multiplier.
// Contents:
//   state_t       - control FSM states (IDLE, BUSY, DONE)
//   digit_t       - Booth digit select (zero, +X, +2X, -X, -2X)
//   booth_iters   - number of Booth digits retired for an XLEN-bit multiply
//   booth_decode  - maps a 3-bit multiplier window to a digit select
package booth_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_POS  = 3'd1,
    DIG_POS2 = 3'd2,
    DIG_NEG  = 3'd3,
    DIG_NEG2 = 3'd4
  } digit_t;

  // Operands are extended by two bits, so XLEN+2 bits are recoded two at a time.
  function automatic int booth_iters(input int xlen);
    return xlen / 2 + 1;
  endfunction

  function automatic digit_t booth_decode(input logic [2:0] w);
    digit_t d;
    case (w)
      3'b001, 3'b010: d = DIG_POS;
      3'b011:         d = DIG_POS2;
      3'b100:         d = DIG_NEG2;
      3'b101, 3'b110: d = DIG_NEG;
      default:        d = DIG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_mul_iter_if.sv
// Request/response bundle of the Booth MUL unit.
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid && ready. A producer holding valid keeps its payload stable
// until the transfer; ready may depend on state but never on valid.
//   flush                  - synchronous abort of any in-flight op
//   in_valid/in_ready      - request channel carrying a, b, a_signed, b_signed, in_tag
//   out_valid/out_ready    - response channel carrying result, out_tag
// modport master: requester/consumer side; modport slave: the MUL unit.
interface booth_mul_iter_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   a;
  logic [XLEN-1:0]   b;
  logic              a_signed;
  logic              b_signed;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [2*XLEN-1:0] result;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output flush, in_valid, a, b, a_signed, b_signed, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag
  );

  modport slave (
    input  flush, in_valid, a, b, a_signed, b_signed, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag
  );
endinterface

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator (combinational).
//   window - multiplier bits {b[2i+1], b[2i], b[2i-1]}
//   mcand  - current (already shifted) multiplicand, W bits
//   pp     - selected partial product, bitwise inverted for negative digits
//   neg    - carry-in that completes the two's complement negation
module booth_pp_gen
  import booth_mul_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [2:0]   window,
  input  logic [W-1:0] mcand,
  output logic [W-1:0] pp,
  output logic         neg
);

  digit_t dig;

  assign dig = booth_decode(window);

  always_comb begin
    pp  = '0;
    neg = 1'b0;
    case (dig)
      DIG_POS:  pp = mcand;
      DIG_POS2: pp = {mcand[W-2:0], 1'b0};
      DIG_NEG: begin
        pp  = ~mcand;
        neg = 1'b1;
      end
      DIG_NEG2: begin
        pp  = ~{mcand[W-2:0], 1'b0};
        neg = 1'b1;
      end
      default: begin
        pp  = '0;
        neg = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier (execute-stage MUL unit).
// One Booth digit is retired per BUSY cycle; supports mul/mulh/mulhsu/mulhu
// through per-operand signedness. The full 2*XLEN product is returned with
// the request tag.
// Ports:
//   clk       - clock
//   resetn    - asynchronous reset, active-low
//   bus       - booth_mul_iter_if.slave (flush, request and response channels)
//   dbg_state - current FSM state
// XLEN/TAG_W must match the parameters of the connected interface.
module booth_mul_iter
  import booth_mul_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 4,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  booth_mul_iter_if.slave   bus,
  output state_t            dbg_state
);

  localparam int EW = XLEN + 2;           // extended operand width
  localparam int AW = 2 * EW;             // accumulator / multiplicand width
  localparam int N  = booth_iters(XLEN);  // Booth digits per operand
  localparam int CW = $clog2(N + 1);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [AW-1:0]    mcand;
  logic [EW:0]      mreg;
  logic [TAG_W-1:0] tag_q;

  logic [EW-1:0]    ext_a, ext_b;
  logic [AW-1:0]    pp;
  logic             neg;
  logic [AW-1:0]    acc_sum;
  logic [EW:0]      mreg_shift;
  logic             early_done;
  logic             last_iter;
  logic             accept;

  // Two extra bits make an unsigned operand positive in two's complement,
  // so one signed Booth datapath serves all four sign modes.
  assign ext_a = {{2{bus.a_signed & bus.a[XLEN-1]}}, bus.a};
  assign ext_b = {{2{bus.b_signed & bus.b[XLEN-1]}}, bus.b};

  booth_pp_gen #(.W(AW)) u_pp_gen (
    .window (mreg[2:0]),
    .mcand  (mcand),
    .pp     (pp),
    .neg    (neg)
  );

  assign acc_sum    = acc + pp + {{(AW-1){1'b0}}, neg};
  assign mreg_shift = {{2{mreg[EW]}}, mreg[EW:2]};

  // Once the remaining multiplier bits are all-0s or all-1s, every further
  // window is 000 or 111 and contributes nothing.
  assign early_done = EARLY_OUT && ((mreg_shift == '0) || (mreg_shift == '1));
  assign last_iter  = (cnt == CW'(N - 1)) || early_done;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            accept     = 1'b1;
            state_next = BUSY;
          end
        end
        BUSY: begin
          if (last_iter) state_next = DONE;
        end
        DONE: begin
          if (bus.out_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
      mreg  <= '0;
      tag_q <= '0;
    end else if (accept) begin
      cnt   <= '0;
      acc   <= '0;
      mcand <= {{(AW-EW){ext_a[EW-1]}}, ext_a};
      mreg  <= {ext_b, 1'b0};
      tag_q <= bus.in_tag;
    end else if (state == BUSY) begin
      cnt   <= cnt + CW'(1);
      acc   <= acc_sum;
      mcand <= {mcand[AW-3:0], 2'b00};
      mreg  <= mreg_shift;
    end
  end

  // acc only changes in BUSY, so result is stable for the whole DONE phase.
  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = acc[2*XLEN-1:0];
  assign bus.out_tag   = tag_q;
  assign dbg_state     = state;

endmodule

// File: tb/tb_booth_mul_iter.sv
module tb_booth_mul_iter;
  import booth_mul_pkg::*;

  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
  localparam int RW    = 2 * XLEN;
  localparam int NLAT  = 17;

  typedef struct {
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic             as;
    logic             bs;
    logic [TAG_W-1:0] tag;
    logic [RW-1:0]    exp;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  booth_mul_iter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) if0 ();
  booth_mul_iter_if #(.XLEN(XLEN), .TAG_W(TAG_W)) if1 ();
  state_t st0, st1;

  booth_mul_iter #(.XLEN(XLEN), .TAG_W(TAG_W), .EARLY_OUT(1'b0)) u_dut0 (
    .clk(clk), .resetn(resetn), .bus(if0.slave), .dbg_state(st0)
  );
  booth_mul_iter #(.XLEN(XLEN), .TAG_W(TAG_W), .EARLY_OUT(1'b1)) u_dut1 (
    .clk(clk), .resetn(resetn), .bus(if1.slave), .dbg_state(st1)
  );

  int checks = 0;
  int errors = 0;
  logic [TAG_W+RW-1:0] exp_q[$];
  vec_t vecs[10];

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] ref_mul(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                            input logic as, input logic bs);
    logic [RW-1:0] ea, eb;
    ea = as ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    eb = bs ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    return ea * eb;
  endfunction

  // driver tasks
  function automatic logic rd_in_ready(input int sel);
    return (sel == 0) ? if0.in_ready : if1.in_ready;
  endfunction
  function automatic logic rd_out_valid(input int sel);
    return (sel == 0) ? if0.out_valid : if1.out_valid;
  endfunction
  function automatic logic [RW-1:0] rd_result(input int sel);
    return (sel == 0) ? if0.result : if1.result;
  endfunction
  function automatic logic [TAG_W-1:0] rd_tag(input int sel);
    return (sel == 0) ? if0.out_tag : if1.out_tag;
  endfunction

  task automatic drive_req(input int sel, input vec_t v);
    if (sel == 0) begin
      if0.a = v.a; if0.b = v.b; if0.a_signed = v.as; if0.b_signed = v.bs;
      if0.in_tag = v.tag; if0.in_valid = 1'b1;
    end else begin
      if1.a = v.a; if1.b = v.b; if1.a_signed = v.as; if1.b_signed = v.bs;
      if1.in_tag = v.tag; if1.in_valid = 1'b1;
    end
  endtask

  task automatic set_in_valid(input int sel, input logic v);
    if (sel == 0) if0.in_valid = v; else if1.in_valid = v;
  endtask

  task automatic set_out_ready(input int sel, input logic v);
    if (sel == 0) if0.out_ready = v; else if1.out_ready = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int sel);
    int n = 0;
    while (!rd_in_ready(sel) && n < 200) begin
      tick();
      n++;
    end
    if (!rd_in_ready(sel)) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout dut=%0d act=0 exp=1", sel);
    end
  endtask

  // Issue one request; returns number of edges from accept to out_valid.
  task automatic issue_and_wait(input int sel, input vec_t v, output int cyc);
    wait_ready(sel);
    drive_req(sel, v);
    tick();
    set_in_valid(sel, 1'b0);
    cyc = 0;
    while (!rd_out_valid(sel) && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_op(input int sel, input vec_t v, input int exp_lat, input string name);
    int cyc;
    issue_and_wait(sel, v, cyc);
    check({name, "_valid"}, RW'(rd_out_valid(sel)), RW'(1));
    if (exp_lat >= 0) check({name, "_lat"}, RW'(cyc), RW'(exp_lat));
    check({name, "_result"}, rd_result(sel), v.exp);
    check({name, "_tag"}, RW'(rd_tag(sel)), RW'(v.tag));
    set_out_ready(sel, 1'b1);
    tick();
    set_out_ready(sel, 1'b0);
    check({name, "_ready_after"}, RW'(rd_in_ready(sel)), RW'(1));
  endtask

  function automatic logic [XLEN-1:0] pick_operand();
    int k;
    k = $urandom_range(0, 3);
    case (k)
      0: return XLEN'($urandom());
      1: return XLEN'($urandom_range(0, 255));
      2: return -XLEN'($urandom_range(0, 255));
      default: begin
        case ($urandom_range(0, 4))
          0: return 32'h0000_0000;
          1: return 32'h0000_0001;
          2: return 32'hFFFF_FFFF;
          3: return 32'h8000_0000;
          default: return 32'h7FFF_FFFF;
        endcase
      end
    endcase
  endfunction

  // scoreboard: driver pushes expected {tag,product}, monitor pops on response
  task automatic run_random(input int sel, input int n);
    int got;
    int cyc;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          vec_t v;
          int mode;
          mode = $urandom_range(0, 3);
          v.as = mode[1];
          v.bs = mode[0];
          v.a = pick_operand();
          v.b = pick_operand();
          v.tag = TAG_W'($urandom_range(0, 15));
          v.exp = '0;
          wait_ready(sel);
          exp_q.push_back({v.tag, ref_mul(v.a, v.b, v.as, v.bs)});
          drive_req(sel, v);
          tick();
          set_in_valid(sel, 1'b0);
        end
      end
      begin
        got = 0;
        cyc = 0;
        while (got < n && cyc < n * 80) begin
          logic r;
          r = 1'($urandom_range(0, 1));
          set_out_ready(sel, r);
          if (rd_out_valid(sel) && r) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL rand_unexpected dut=%0d act=%h exp=none", sel, rd_result(sel));
            end else begin
              logic [TAG_W+RW-1:0] e;
              e = exp_q.pop_front();
              check("rand_result", rd_result(sel), e[RW-1:0]);
              check("rand_tag", RW'(rd_tag(sel)), RW'(e[TAG_W+RW-1:RW]));
            end
            got++;
          end
          tick();
          cyc++;
        end
        set_out_ready(sel, 1'b0);
        if (got < n) begin
          checks++;
          errors++;
          $display("FAIL rand_timeout dut=%0d act=%0d exp=%0d", sel, got, n);
        end
      end
    join
  endtask

  initial begin
    int cyc;
    int seen;
    vec_t v;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 4'h1, 64'hFFFFFFFE00000001};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 4'h2, 64'h0000000000000001};
    vecs[2] = '{32'h80000000, 32'h80000000, 1'b1, 1'b1, 4'h3, 64'h4000000000000000};
    vecs[3] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 4'hA, 64'hFFFFFFFE00000002};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 4'h4, 64'h4000000000000000};
    vecs[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 4'h5, 64'hFFFFFFFF00000001};
    vecs[6] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 4'h6, 64'hC000000080000000};
    vecs[7] = '{32'h00000000, 32'h12345678, 1'b0, 1'b0, 4'h7, 64'h0000000000000000};
    vecs[8] = '{32'h00000003, 32'hFFFFFFFB, 1'b1, 1'b1, 4'h8, 64'hFFFFFFFFFFFFFFF1};
    vecs[9] = '{32'h00010000, 32'h00010000, 1'b0, 1'b0, 4'h9, 64'h0000000100000000};

    if0.flush = 1'b0; if0.in_valid = 1'b0; if0.a = '0; if0.b = '0;
    if0.a_signed = 1'b0; if0.b_signed = 1'b0; if0.in_tag = '0; if0.out_ready = 1'b0;
    if1.flush = 1'b0; if1.in_valid = 1'b0; if1.a = '0; if1.b = '0;
    if1.a_signed = 1'b0; if1.b_signed = 1'b0; if1.in_tag = '0; if1.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", RW'(if0.in_ready), RW'(1));
    check("rst_out_valid", RW'(if0.out_valid), RW'(0));
    check("rst_result", if0.result, RW'(0));
    check("rst_tag", RW'(if0.out_tag), RW'(0));
    check("rst_state0", RW'(st0), RW'(IDLE));
    check("rst_state1", RW'(st1), RW'(IDLE));
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // table-driven vectors, fixed latency on the non-early-exit unit
    for (int i = 0; i < 10; i++) run_op(0, vecs[i], NLAT, $sformatf("vec%0d", i));
    // same vectors through the early-exit unit, result only
    for (int i = 0; i < 10; i++) run_op(1, vecs[i], -1, $sformatf("evec%0d", i));

    // backpressure: hold out_ready low for 5 cycles in DONE
    issue_and_wait(0, vecs[3], cyc);
    check("bp_lat", RW'(cyc), RW'(NLAT));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_result", if0.result, 64'hFFFFFFFE00000002);
      check("bp_tag", RW'(if0.out_tag), RW'(4'hA));
      check("bp_in_ready", RW'(if0.in_ready), RW'(0));
      check("bp_out_valid", RW'(if0.out_valid), RW'(1));
    end
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;
    check("bp_release_ready", RW'(if0.in_ready), RW'(1));
    check("bp_release_valid", RW'(if0.out_valid), RW'(0));

    // flush during the fifth BUSY cycle
    wait_ready(0);
    drive_req(0, vecs[0]);
    tick();
    if0.in_valid = 1'b0;
    repeat (4) tick();
    check("fl_busy", RW'(st0), RW'(BUSY));
    if0.flush = 1'b1;
    tick();
    if0.flush = 1'b0;
    check("fl_in_ready", RW'(if0.in_ready), RW'(1));
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (if0.out_valid) seen++;
      tick();
    end
    check("fl_no_valid", RW'(seen), RW'(0));

    // flush in IDLE with in_valid set accepts nothing
    drive_req(0, vecs[1]);
    if0.flush = 1'b1;
    tick();
    if0.flush = 1'b0;
    if0.in_valid = 1'b0;
    check("fl_idle_state", RW'(st0), RW'(IDLE));
    check("fl_idle_ready", RW'(if0.in_ready), RW'(1));

    // asynchronous reset mid-BUSY
    wait_ready(0);
    drive_req(0, vecs[5]);
    tick();
    if0.in_valid = 1'b0;
    repeat (3) tick();
    #1;
    resetn = 1'b0;
    #1;
    check("ar_in_ready", RW'(if0.in_ready), RW'(1));
    check("ar_out_valid", RW'(if0.out_valid), RW'(0));
    check("ar_result", if0.result, RW'(0));
    check("ar_tag", RW'(if0.out_tag), RW'(0));
    @(negedge clk);
    resetn = 1'b1;
    tick();
    run_op(0, vecs[6], NLAT, "ar_restart");

    // early exit cases
    v = '{32'd3, 32'd5, 1'b0, 1'b0, 4'hC, 64'd15};
    run_op(1, v, 2, "eo_3x5");
    v = '{32'h00001234, 32'd0, 1'b0, 1'b0, 4'hD, 64'd0};
    run_op(1, v, 1, "eo_bzero");
    v = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 4'hE, 64'd1};
    run_op(1, v, 1, "eo_m1xm1");

    // random operations in all sign modes with random out_ready
    run_random(0, 700);
    run_random(1, 700);
    check("sb_empty", RW'(exp_q.size()), RW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
